// File: rtl/pc_pkg.sv
// Shared types and the branch-condition evaluator for the program-counter unit.
package pc_pkg;

   typedef enum logic [2:0] {
      SEQ   = 3'd0,
      BR    = 3'd1,
      REG   = 3'd2,
      CALL  = 3'd3,
      CALLR = 3'd4,
      RET   = 3'd5
   } pc_mode_t;

   typedef enum logic [2:0] {
      AL = 3'd0,
      EQ = 3'd1,
      NE = 3'd2,
      LT = 3'd3,
      LE = 3'd4,
      GE = 3'd5,
      GT = 3'd6,
      NV = 3'd7
   } br_cond_t;

   // Signed comparisons derived from the N/V/Z flags of a preceding subtract.
   function automatic logic cond_true(input br_cond_t cond, input logic n,
                                      input logic v, input logic z);
      logic lt;
      lt = n ^ v;
      case (cond)
         AL:      cond_true = 1'b1;
         EQ:      cond_true = z;
         NE:      cond_true = !z;
         LT:      cond_true = lt;
         LE:      cond_true = lt | z;
         GE:      cond_true = !lt;
         GT:      cond_true = !lt & !z;
         default: cond_true = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with write pointer and occupancy count.
module ras_stack
   import pc_pkg::*;
#(
   parameter int AW        = 9,
   parameter int RAS_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          clr,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] dout,
   output logic          empty,
   output logic          full,
   output logic          ovf,
   output logic          unf
);

   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [PW:0]   count;
   logic [AW-1:0] mem [RAS_DEPTH];

   assign rp    = wp - PW'(1);
   assign dout  = mem[rp];
   assign empty = (count == '0);
   assign full  = (count == (PW+1)'(RAS_DEPTH));
   assign ovf   = push & full;
   assign unf   = pop & empty;

   // A push into a full stack overwrites the oldest slot, which is the one at wp.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp    <= '0;
         count <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wp    <= '0;
         count <= '0;
      end else if (push) begin
         mem[wp] <= din;
         wp      <= wp + PW'(1);
         if (!full) count <= count + (PW+1)'(1);
      end else if (pop && !empty) begin
         wp    <= rp;
         count <= count - (PW+1)'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with conditional branches, register jumps and call/return
// through a hardware return-address stack.
module pc_unit
   import pc_pkg::*;
#(
   parameter int            AW        = 9,
   parameter int            OFFW      = 8,
   parameter int            RAS_DEPTH = 4,
   parameter logic [AW-1:0] RESET_VEC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            advance,
   input  logic            pc_clr,
   input  logic [2:0]      mode,
   input  logic [2:0]      cond,
   input  logic [OFFW-1:0] offset,
   input  logic [AW-1:0]   target,
   input  logic            n_flag,
   input  logic            v_flag,
   input  logic            z_flag,
   output logic [AW-1:0]   pc,
   output logic [AW-1:0]   link,
   output logic            taken,
   output logic            ras_empty,
   output logic            ras_full,
   output logic [1:0]      ras_err
);

   logic [AW-1:0] seq, rel, off_ext, ras_dout;
   logic [AW-1:0] pc_nxt, link_nxt;
   logic          taken_nxt, push, pop, ovf, unf, br_ok;

   assign off_ext = AW'($signed(offset));
   assign seq     = pc + AW'(1);
   assign rel     = seq + off_ext;
   assign br_ok   = cond_true(br_cond_t'(cond), n_flag, v_flag, z_flag);

   ras_stack #(.AW(AW), .RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clr   (pc_clr),
      .din   (seq),
      .dout  (ras_dout),
      .empty (ras_empty),
      .full  (ras_full),
      .ovf   (ovf),
      .unf   (unf)
   );

   // pc_clr wins over advance; reserved modes fall through to sequential.
   always_comb begin
      pc_nxt    = pc;
      link_nxt  = link;
      taken_nxt = taken;
      push      = 1'b0;
      pop       = 1'b0;
      if (pc_clr) begin
         pc_nxt    = RESET_VEC;
         taken_nxt = 1'b0;
      end else if (advance) begin
         case (mode)
            BR: begin
               pc_nxt    = br_ok ? rel : seq;
               taken_nxt = br_ok;
            end
            REG: begin
               pc_nxt    = target;
               taken_nxt = 1'b1;
            end
            CALL: begin
               pc_nxt    = rel;
               link_nxt  = seq;
               push      = 1'b1;
               taken_nxt = 1'b1;
            end
            CALLR: begin
               pc_nxt    = target;
               link_nxt  = seq;
               push      = 1'b1;
               taken_nxt = 1'b1;
            end
            RET: begin
               pc_nxt    = ras_empty ? target : ras_dout;
               pop       = 1'b1;
               taken_nxt = 1'b1;
            end
            default: begin
               pc_nxt    = seq;
               taken_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= RESET_VEC;
         link    <= '0;
         taken   <= 1'b0;
         ras_err <= 2'b00;
      end else begin
         pc      <= pc_nxt;
         link    <= link_nxt;
         taken   <= taken_nxt;
         ras_err <= ras_err | {unf, ovf};
      end
   end

endmodule
